// File: rtl/mc_port_arbiter_if.sv
// rtl/mc_port_arbiter_if.sv - requester-side and downstream bus bundle for mc_port_arbiter
interface mc_port_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int DW        = 32,
  parameter int AW        = 26
);
  localparam int GW = $clog2(NUM_PORTS);
  localparam int SW = DW / 8;

  logic [NUM_PORTS-1:0]    p_req;
  logic [NUM_PORTS-1:0]    p_we;
  logic [NUM_PORTS*AW-1:0] p_addr;
  logic [NUM_PORTS*DW-1:0] p_wdata;
  logic [NUM_PORTS*SW-1:0] p_sel;
  logic [NUM_PORTS-1:0]    p_ack;
  logic [NUM_PORTS-1:0]    p_err;
  logic [DW-1:0]           p_rdata;

  logic                    m_cyc;
  logic                    m_stb;
  logic                    m_we;
  logic [AW-1:0]           m_addr;
  logic [DW-1:0]           m_wdata;
  logic [SW-1:0]           m_sel;
  logic                    m_ack;
  logic [DW-1:0]           m_rdata;

  logic [GW-1:0]           grant_id;

  // Arbiter view: serves the requesters and drives the controller port.
  modport slave (
    input  p_req, p_we, p_addr, p_wdata, p_sel, m_ack, m_rdata,
    output p_ack, p_err, p_rdata, m_cyc, m_stb, m_we, m_addr, m_wdata, m_sel, grant_id
  );

  // Environment view: requesters plus the downstream controller.
  modport master (
    output p_req, p_we, p_addr, p_wdata, p_sel, m_ack, m_rdata,
    input  p_ack, p_err, p_rdata, m_cyc, m_stb, m_we, m_addr, m_wdata, m_sel, grant_id
  );
endinterface

// File: rtl/mc_port_arbiter.sv
// rtl/mc_port_arbiter.sv - round-robin N-port front-end onto one wishbone-style master port
// Optional ARB_TIMEOUT_EN: abort with p_err after TIMEOUT BUSY cycles without m_ack.
module mc_port_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DW        = 32,
  parameter int AW        = 26,
  parameter int TIMEOUT   = 255
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  mc_port_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_PORTS);
  localparam int SW = DW / 8;

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || (DW % 8) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("mc_port_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [GW-1:0]  rr_ptr;
  logic [GW-1:0]  grant;
  logic           we_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic [SW-1:0]  sel_q;
  logic [DW-1:0]  rdata_q;
  logic           err_q;
  logic           err_nxt;
  logic           found;
  logic [GW-1:0]  pick;
  logic [GW:0]    idx;
  logic [GW-1:0]  pick_inc;
  logic           take_grant;
  logic           tmo_hit;

  // First requester at or after rr_ptr, searching modulo NUM_PORTS.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = {1'b0, rr_ptr} + (GW+1)'(i);
      if (idx >= (GW+1)'(NUM_PORTS)) begin
        idx = idx - (GW+1)'(NUM_PORTS);
      end
      if (!found && bus.p_req[idx[GW-1:0]]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
  end

  assign pick_inc   = (pick == GW'(NUM_PORTS - 1)) ? '0 : pick + GW'(1);
  assign take_grant = (state == IDLE) && found;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 255) ? 16 : 8;
  logic [CW-1:0] tmo_cnt;

  // Counts completed BUSY cycles; the abort fires at the end of the TIMEOUT-th one.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_cnt <= '0;
    end else if (state == BUSY) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // m_ack has priority over the timeout when both land on the same cycle.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
          err_nxt   = 1'b0;
        end
      end
      BUSY: begin
        if (bus.m_ack) begin
          state_nxt = RESP;
          err_nxt   = 1'b0;
        end else if (tmo_hit) begin
          state_nxt = RESP;
          err_nxt   = 1'b1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        err_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rr_ptr  <= '0;
      grant   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_nxt;
      if (take_grant) begin
        grant   <= pick;
        rr_ptr  <= pick_inc;
        we_q    <= bus.p_we[pick];
        addr_q  <= bus.p_addr[int'(pick)*AW +: AW];
        wdata_q <= bus.p_wdata[int'(pick)*DW +: DW];
        sel_q   <= bus.p_sel[int'(pick)*SW +: SW];
      end
      // Write acks carry no data, so p_rdata keeps the last read result.
      if (state == BUSY && bus.m_ack && !we_q) begin
        rdata_q <= bus.m_rdata;
      end
    end
  end

  assign bus.m_cyc    = (state == BUSY);
  assign bus.m_stb    = (state == BUSY);
  assign bus.m_we     = we_q;
  assign bus.m_addr   = addr_q;
  assign bus.m_wdata  = wdata_q;
  assign bus.m_sel    = sel_q;
  assign bus.p_rdata  = rdata_q;
  assign bus.grant_id = grant;
  assign bus.p_ack    = (state == RESP && !err_q) ? (NUM_PORTS'(1) << grant) : '0;

`ifdef ARB_TIMEOUT_EN
  assign bus.p_err    = (state == RESP && err_q) ? (NUM_PORTS'(1) << grant) : '0;
`else
  assign bus.p_err    = '0;
`endif
endmodule

// File: tb/tb_mc_port_arbiter.sv
// tb/tb_mc_port_arbiter.sv - directed and randomized checks of mc_port_arbiter against a transaction model
module tb_mc_port_arbiter;
  localparam int NP  = 4;
  localparam int DW  = 32;
  localparam int AW  = 26;
  localparam int SW  = DW / 8;
  localparam int TMO = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_port_arbiter_if #(.NUM_PORTS(NP), .DW(DW), .AW(AW)) bus ();

  mc_port_arbiter #(.NUM_PORTS(NP), .DW(DW), .AW(AW), .TIMEOUT(TMO)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: phase 0 waiting, 1 downstream cycle open, 2 response pulse.
  int            m_phase = 0;
  int            m_rr    = 0;
  int            m_g     = 0;
  int            m_busy  = 0;
  bit            m_err   = 0;
  logic          m_we    = 0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [SW-1:0] m_sel   = '0;
  logic [DW-1:0] m_rd    = '0;

  function automatic int pick_port(input int rr, input logic [NP-1:0] req);
    for (int k = 0; k < NP; k++) begin
      if (req[(rr + k) % NP]) return (rr + k) % NP;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_rr = 0; m_g = 0; m_busy = 0; m_err = 0;
      m_we = 0; m_addr = '0; m_wdata = '0; m_sel = '0; m_rd = '0;
    end else begin
      case (m_phase)
        0: begin
          int p;
          p = pick_port(m_rr, bus.p_req);
          if (p >= 0) begin
            m_g     = p;
            m_rr    = (p + 1) % NP;
            m_we    = bus.p_we[p];
            m_addr  = bus.p_addr[p*AW +: AW];
            m_wdata = bus.p_wdata[p*DW +: DW];
            m_sel   = bus.p_sel[p*SW +: SW];
            m_busy  = 0;
            m_phase = 1;
          end
        end
        1: begin
          if (bus.m_ack) begin
            if (!m_we) m_rd = bus.m_rdata;
            m_err   = 0;
            m_phase = 2;
          end else begin
            m_busy++;
`ifdef ARB_TIMEOUT_EN
            if (m_busy == TMO) begin
              m_err   = 1;
              m_phase = 2;
            end
`endif
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  bit cmp_on = 0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_cyc",    bus.m_cyc,    64'(m_phase == 1));
      chk("m_stb",    bus.m_stb,    64'(m_phase == 1));
      chk("m_we",     bus.m_we,     64'(m_we));
      chk("m_addr",   bus.m_addr,   64'(m_addr));
      chk("m_wdata",  bus.m_wdata,  64'(m_wdata));
      chk("m_sel",    bus.m_sel,    64'(m_sel));
      chk("grant_id", bus.grant_id, 64'(m_g));
      chk("p_rdata",  bus.p_rdata,  64'(m_rd));
      chk("p_ack",    bus.p_ack,    (m_phase == 2 && !m_err) ? 64'(1) << m_g : 64'(0));
      chk("p_err",    bus.p_err,    (m_phase == 2 &&  m_err) ? 64'(1) << m_g : 64'(0));
    end
  end

  int grants[$];
  always @(negedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (bus.p_ack[i] || bus.p_err[i]) grants.push_back(i);
    end
  end

  // Requesters: hold p_req until the pulse; sticky ports re-request immediately.
  logic [NP-1:0] sticky  = '0;
  bit            rand_on = 0;
  always @(negedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if ((bus.p_ack[i] || bus.p_err[i]) && !sticky[i]) begin
        bus.p_req[i] = 1'b0;
      end else if (rand_on && !bus.p_req[i] && $urandom_range(3) == 0) begin
        bus.p_we[i]              = 1'($urandom_range(1));
        bus.p_addr[i*AW +: AW]   = AW'($urandom_range(15) * 4);
        bus.p_wdata[i*DW +: DW]  = $urandom;
        bus.p_sel[i*SW +: SW]    = SW'($urandom_range(1, 15));
        bus.p_req[i]             = 1'b1;
      end
    end
  end

  // Downstream controller: small memory, random ack delay, optional stray acks when idle.
  bit            ctrl_auto = 1;
  bit            noise_on  = 0;
  int unsigned   dly       = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  always @(negedge clk) begin
    if (ctrl_auto) begin
      if (bus.m_ack) begin
        bus.m_ack = 1'b0;
      end else if (bus.m_cyc) begin
        if (dly == 0) begin
          if (bus.m_we) begin
            mem[bus.m_addr] = bus.m_wdata;
            bus.m_rdata     = $urandom;
          end else begin
            bus.m_rdata = mem.exists(bus.m_addr) ? mem[bus.m_addr] : $urandom;
          end
          bus.m_ack = 1'b1;
          dly       = $urandom_range(4);
        end else begin
          dly--;
        end
      end else if (noise_on && $urandom_range(7) == 0) begin
        bus.m_rdata = $urandom;
        bus.m_ack   = 1'b1;
      end
    end
  end

  task automatic raise(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
    bus.p_we[p]             = we;
    bus.p_addr[p*AW +: AW]  = a;
    bus.p_wdata[p*DW +: DW] = d;
    bus.p_sel[p*SW +: SW]   = s;
    bus.p_req[p]            = 1'b1;
  endtask

  task automatic wait_quiet(input string nm, input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (bus.p_req == '0 && !bus.m_cyc && bus.p_ack == '0 && bus.p_err == '0) ok = 1;
    end
    chk(nm, 64'(ok), 64'(1));
  endtask

  task automatic wait_grants(input string nm, input int n, input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (grants.size() >= n) ok = 1;
    end
    chk(nm, 64'(ok), 64'(1));
  endtask

  task automatic wait_cyc(input string nm, input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (bus.m_cyc) ok = 1;
    end
    chk(nm, 64'(ok), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp2[8];
    int exp3[2];
    int n;
    bit saw;
    exp2 = '{0, 1, 2, 3, 0, 3, 0, 3};
    exp3 = '{3, 1};

    bus.p_req = '0; bus.p_we = '0; bus.p_addr = '0; bus.p_wdata = '0; bus.p_sel = '0;
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    repeat (3) @(negedge clk);
    cmp_on = 1;
    chk("rst_m_cyc", bus.m_cyc, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_p_ack", bus.p_ack, 0);
    chk("rst_rdata", bus.p_rdata, 0);
    rst_n = 1'b1;

    // All four at once from reset, ports 0 and 3 keep requesting.
    @(negedge clk);
    grants.delete();
    sticky = 4'b1001;
    for (int p = 0; p < NP; p++) raise(p, 1'b0, AW'(p * 4), 32'h0, 4'hF);
    wait_grants("t2_wait", 8, 300);
    sticky = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < grants.size()) chk($sformatf("t2_order%0d", k), 64'(grants[k]), 64'(exp2[k]));
    end
    wait_quiet("t2_quiet", 300);

    // Port 2 alone leaves rr_ptr at 3; then ports 1 and 3 together wrap.
    grants.delete();
    raise(2, 1'b0, 26'h8, 32'h0, 4'hF);
    wait_quiet("t3_q1", 100);
    grants.delete();
    raise(1, 1'b0, 26'hC, 32'h0, 4'hF);
    raise(3, 1'b0, 26'h10, 32'h0, 4'hF);
    wait_grants("t3_wait", 2, 200);
    for (int k = 0; k < 2; k++) begin
      if (k < grants.size()) chk($sformatf("t3_order%0d", k), 64'(grants[k]), 64'(exp3[k]));
    end
    wait_quiet("t3_q2", 200);

    // Single-port write then read-back.
    raise(2, 1'b1, 26'h100, 32'hDEADBEEF, 4'hF);
    wait_cyc("t1_cyc", 50);
    chk("t1_m_addr", bus.m_addr, 26'h100);
    chk("t1_m_wdata", bus.m_wdata, 32'hDEADBEEF);
    chk("t1_m_we", bus.m_we, 1);
    chk("t1_m_sel", bus.m_sel, 4'hF);
    wait_quiet("t1_q1", 100);
    raise(2, 1'b0, 26'h100, 32'h0, 4'hF);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.p_ack[2]) n++;
      if (n > 0 && bus.p_req == '0 && !bus.m_cyc && bus.p_ack == '0) break;
    end
    chk("t1_ack_count", 64'(n), 1);
    chk("t1_rdata", bus.p_rdata, 32'hDEADBEEF);

    // Requester drops p_req mid-transaction; then a stray m_ack while idle.
    ctrl_auto = 0;
    bus.m_ack = 1'b0;
    @(negedge clk);
    raise(1, 1'b0, 26'h20, 32'h0, 4'hF);
    wait_cyc("t5_cyc", 50);
    bus.p_req[1] = 1'b0;
    repeat (3) @(negedge clk);
    bus.m_rdata = 32'h1234_5678;
    bus.m_ack   = 1'b1;
    @(negedge clk);
    bus.m_ack = 1'b0;
    chk("t5_ack", bus.p_ack, 4'b0010);
    chk("t5_rdata", bus.p_rdata, 32'h1234_5678);
    @(negedge clk);
    bus.m_rdata = 32'hFFFF_0000;
    bus.m_ack   = 1'b1;
    @(negedge clk);
    bus.m_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t5_stray_ack", bus.p_ack, 0);
      chk("t5_stray_cyc", bus.m_cyc, 0);
      @(negedge clk);
    end
    chk("t5_rdata_hold", bus.p_rdata, 32'h1234_5678);

    // Reset mid-transaction, then rr_ptr must be back at 0.
    raise(2, 1'b0, 26'h40, 32'h0, 4'hF);
    wait_cyc("t4_cyc", 50);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_cyc_clear", bus.m_cyc, 0);
    chk("t4_ack_clear", bus.p_ack, 0);
    bus.p_req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    ctrl_auto = 1;
    grants.delete();
    raise(3, 1'b0, 26'h44, 32'h0, 4'hF);
    raise(0, 1'b0, 26'h48, 32'h0, 4'hF);
    wait_grants("t4_wait", 2, 200);
    if (grants.size() >= 2) begin
      chk("t4_first", 64'(grants[0]), 0);
      chk("t4_second", 64'(grants[1]), 3);
    end
    wait_quiet("t4_quiet", 200);

    // Controller never acknowledges.
    ctrl_auto = 0;
    bus.m_ack = 1'b0;
    @(negedge clk);
    raise(0, 1'b0, 26'h80, 32'h0, 4'hF);
    n   = 0;
    saw = 0;
    for (int k = 0; k < 60 && !saw; k++) begin
      @(negedge clk);
      if (bus.m_cyc) n++;
      if (bus.p_err[0]) saw = 1;
    end
`ifdef ARB_TIMEOUT_EN
    chk("t6_busy_cycles", 64'(n), 64'(TMO));
    chk("t6_err_seen", 64'(saw), 1);
    chk("t6_no_ack", bus.p_ack, 0);
`else
    chk("t6_busy_hold", 64'(n), 60);
    chk("t6_no_err", 64'(saw), 0);
    bus.m_rdata = 32'hA5A5_5A5A;
    bus.m_ack   = 1'b1;
    @(negedge clk);
    bus.m_ack = 1'b0;
`endif
    wait_quiet("t6_quiet", 100);
    ctrl_auto = 1;

    // Randomized traffic with stray acks, checked cycle by cycle against the model.
    rand_on  = 1;
    noise_on = 1;
    repeat (1500) @(negedge clk);
    rand_on  = 0;
    noise_on = 0;
    wait_quiet("rand_quiet", 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
